// File: rtl/lcd_ctrl_pkg.sv
// Shared types and constants for the character-LCD 4-bit write sequencer.
// Optional power-on init is selected in lcd_write_sequencer by LCD_POWERON_INIT_EN.
package lcd_ctrl_pkg;

    typedef enum logic [3:0] {
        StPwrWait,
        StInitNib,
        StIdle,
        StSetupHi,
        StPulseHi,
        StGap,
        StSetupLo,
        StPulseLo,
        StExecWait
    } state_t;

    typedef enum logic [1:0] {
        PhSetup,
        PhPulse,
        PhWait
    } init_phase_t;

    localparam int unsigned NumInitNibbles = 4;
    // Nibble i of the init sequence lives in bits [4*i +: 4].
    localparam logic [15:0] InitNibbles  = {4'h2, 4'h3, 4'h3, 4'h3};
    localparam logic [7:0]  ClearHomeMax = 8'h03;

    // Counters hold (delay - 1), so values 0 .. max_val-1 must fit.
    function automatic int unsigned counter_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val);
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter shared by every wait state; done pulses for one cycle
// when a loaded count has run out.
module lcd_delay_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             done
);

    logic [WIDTH-1:0] count_q;
    logic             armed_q;

    always_ff @(posedge clk) begin
        if (load) begin
            count_q <= value;
            armed_q <= 1'b1;
        end else if (count_q != '0) begin
            count_q <= count_q - WIDTH'(1);
        end else begin
            armed_q <= 1'b0;
        end
    end

    assign done = armed_q && (count_q == '0);

endmodule

// File: rtl/lcd_write_sequencer.sv
// Request-driven byte writer for the LCD 4-bit bus: high nibble, gap, low nibble, exec wait.
// Define LCD_POWERON_INIT_EN to run the power-on init nibble sequence after every reset.
module lcd_write_sequencer
    import lcd_ctrl_pkg::*;
#(
    parameter int unsigned T_SETUP      = 2,
    parameter int unsigned T_EPULSE     = 12,
    parameter int unsigned T_NIBBLE_GAP = 50,
    parameter int unsigned T_CMD_WAIT   = 2000,
    parameter int unsigned T_CLEAR_WAIT = 82000,
    parameter int unsigned T_POWERON    = 750000,
    parameter int unsigned T_INIT1      = 205000,
    parameter int unsigned T_INIT2      = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       busy,
    output logic       sf_e,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [3:0] lcd_d
);

    localparam int unsigned MaxDelay =
        max2(max2(max2(T_SETUP, T_EPULSE), max2(T_NIBBLE_GAP, T_CMD_WAIT)),
             max2(max2(T_CLEAR_WAIT, T_POWERON), max2(T_INIT1, T_INIT2)));
    localparam int unsigned CW = counter_width(MaxDelay);

    typedef logic [CW-1:0] cnt_t;

`ifdef LCD_POWERON_INIT_EN
    localparam state_t ResetState = StPwrWait;
`else
    localparam state_t ResetState = StIdle;
`endif

    state_t      state_q, state_d;
    init_phase_t phase_q, phase_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  data_q, data_d;
    logic        rs_q, rs_d;
    logic        long_q, long_d;

    logic        load_ns;
    cnt_t        next_value;
    logic        tmr_load;
    cnt_t        tmr_value;
    logic        tmr_done;

    logic        e_d, lrs_d, ready_d, busy_d;
    logic [3:0]  d_d;
    logic        accept;

    function automatic cnt_t init_wait(input logic [1:0] idx);
        case (idx)
            2'd0:    return cnt_t'(T_INIT1 - 1);
            2'd1:    return cnt_t'(T_INIT2 - 1);
            default: return cnt_t'(T_CMD_WAIT - 1);
        endcase
    endfunction

    // Reset reloads the timer so PWR_WAIT starts counting on the reset edge itself.
    assign tmr_load  = rst | load_ns;
    assign tmr_value = rst ? cnt_t'(T_POWERON - 1) : next_value;

    lcd_delay_timer #(
        .WIDTH(CW)
    ) u_timer (
        .clk  (clk),
        .load (tmr_load),
        .value(tmr_value),
        .done (tmr_done)
    );

    assign accept = (state_q == StIdle) && req_ready && req_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ResetState;
            phase_q   <= PhSetup;
            idx_q     <= '0;
            data_q    <= '0;
            rs_q      <= 1'b0;
            long_q    <= 1'b0;
            sf_e      <= 1'b1;
            lcd_e     <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_rw    <= 1'b0;
            lcd_d     <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            rs_q      <= rs_d;
            long_q    <= long_d;
            sf_e      <= 1'b1;
            lcd_e     <= e_d;
            lcd_rs    <= lrs_d;
            lcd_rw    <= 1'b0;
            lcd_d     <= d_d;
            req_ready <= ready_d;
            busy      <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        idx_d      = idx_q;
        data_d     = data_q;
        rs_d       = rs_q;
        long_d     = long_q;
        load_ns    = 1'b0;
        next_value = '0;
        unique case (state_q)
            StPwrWait: begin
                if (tmr_done) begin
                    state_d    = StInitNib;
                    phase_d    = PhSetup;
                    idx_d      = '0;
                    load_ns    = 1'b1;
                    next_value = cnt_t'(T_SETUP - 1);
                end
            end
            StInitNib: begin
                if (tmr_done) begin
                    load_ns = 1'b1;
                    unique case (phase_q)
                        PhSetup: begin
                            phase_d    = PhPulse;
                            next_value = cnt_t'(T_EPULSE - 1);
                        end
                        PhPulse: begin
                            phase_d    = PhWait;
                            next_value = init_wait(idx_q);
                        end
                        default: begin
                            if (idx_q == 2'(NumInitNibbles - 1)) begin
                                state_d = StIdle;
                                load_ns = 1'b0;
                            end else begin
                                idx_d      = idx_q + 2'd1;
                                phase_d    = PhSetup;
                                next_value = cnt_t'(T_SETUP - 1);
                            end
                        end
                    endcase
                end
            end
            StIdle: begin
                if (accept) begin
                    data_d     = req_data;
                    rs_d       = req_rs;
                    long_d     = !req_rs && (req_data <= ClearHomeMax);
                    state_d    = StSetupHi;
                    load_ns    = 1'b1;
                    next_value = cnt_t'(T_SETUP - 1);
                end
            end
            StSetupHi: begin
                if (tmr_done) begin
                    state_d    = StPulseHi;
                    load_ns    = 1'b1;
                    next_value = cnt_t'(T_EPULSE - 1);
                end
            end
            StPulseHi: begin
                if (tmr_done) begin
                    state_d    = StGap;
                    load_ns    = 1'b1;
                    next_value = cnt_t'(T_NIBBLE_GAP - 1);
                end
            end
            StGap: begin
                if (tmr_done) begin
                    state_d    = StSetupLo;
                    load_ns    = 1'b1;
                    next_value = cnt_t'(T_SETUP - 1);
                end
            end
            StSetupLo: begin
                if (tmr_done) begin
                    state_d    = StPulseLo;
                    load_ns    = 1'b1;
                    next_value = cnt_t'(T_EPULSE - 1);
                end
            end
            StPulseLo: begin
                if (tmr_done) begin
                    state_d    = StExecWait;
                    load_ns    = 1'b1;
                    next_value = long_q ? cnt_t'(T_CLEAR_WAIT - 1) : cnt_t'(T_CMD_WAIT - 1);
                end
            end
            StExecWait: begin
                if (tmr_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so the registered pins line up with the state.
    always_comb begin
        e_d     = 1'b0;
        lrs_d   = 1'b0;
        d_d     = '0;
        ready_d = 1'b0;
        busy_d  = 1'b1;
        unique case (state_d)
            StInitNib: begin
                d_d = InitNibbles[{idx_d, 2'b00} +: 4];
                e_d = (phase_d == PhPulse);
            end
            StIdle: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                d_d     = data_d[3:0];
                lrs_d   = rs_d;
            end
            StSetupHi, StGap: begin
                d_d   = data_d[7:4];
                lrs_d = rs_d;
            end
            StPulseHi: begin
                d_d   = data_d[7:4];
                lrs_d = rs_d;
                e_d   = 1'b1;
            end
            StSetupLo, StExecWait: begin
                d_d   = data_d[3:0];
                lrs_d = rs_d;
            end
            StPulseLo: begin
                d_d   = data_d[3:0];
                lrs_d = rs_d;
                e_d   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
